// File: rtl/tone_pkg.sv
//------------------------------------------------------------------------------
// tone_pkg: shared tone constants and the period-meter state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tone_pkg;

  localparam int MAIN_CLK_FREQ = 12_000_000;
  localparam int TONE_A_FREQ   = 440;
  localparam int TONE_A_DELAY  = MAIN_CLK_FREQ / TONE_A_FREQ;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

`default_nettype wire

// File: rtl/tone_period_meter_if.sv
//------------------------------------------------------------------------------
// tone_period_meter_if: tone input and measurement results of the period meter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tone_period_meter_if #(
  parameter int CNT_W = 32
);
  logic             TONE_IN;
  logic [CNT_W-1:0] PERIOD_o;
  logic             PERIOD_VALID_o;
  logic             TONE_MATCH_o;
  logic             SIGNAL_LOST_o;
  logic             LED_D9;

  modport master (
    input  TONE_IN,
    output PERIOD_o,
    output PERIOD_VALID_o,
    output TONE_MATCH_o,
    output SIGNAL_LOST_o,
    output LED_D9
  );

  modport slave (
    output TONE_IN,
    input  PERIOD_o,
    input  PERIOD_VALID_o,
    input  TONE_MATCH_o,
    input  SIGNAL_LOST_o,
    input  LED_D9
  );
endinterface

`default_nettype wire

// File: rtl/tone_edge_sync.sv
//------------------------------------------------------------------------------
// tone_edge_sync: 2-flop synchronizer, optional debounce (TONE_DEBOUNCE_EN),
// single-cycle rising-edge pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tone_edge_sync #(
`ifdef TONE_DEBOUNCE_EN
  parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  wire logic CLK_IN,
  input  wire logic RST_N_IN,
  input  wire logic i_tone,
  output logic      o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;
  logic w_level;

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_tone;
      r_sync2 <= r_sync1;
    end
  end

`ifdef TONE_DEBOUNCE_EN
  localparam int               DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  C_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;

  // A new level is taken only after it has been seen on DEBOUNCE_CYCLES
  // consecutive samples; any return to the stable level restarts the count.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == C_DB_LAST) begin
      r_stable <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      r_hist <= 1'b0;
    end else begin
      r_hist <= w_level;
    end
  end

  assign o_rise = w_level & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/tone_period_meter.sv
//------------------------------------------------------------------------------
// tone_period_meter: measures tone period in clock cycles and flags a match
// to the target tone. Optional input debounce via TONE_DEBOUNCE_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tone_period_meter #(
  parameter int MAIN_CLK_FREQ   = tone_pkg::MAIN_CLK_FREQ,
  parameter int TARGET_FREQ     = tone_pkg::TONE_A_FREQ,
  parameter int TOL_CYCLES      = 272,
  parameter int MATCH_COUNT     = 4,
  parameter int TIMEOUT_CYCLES  = 600_000,
`ifdef TONE_DEBOUNCE_EN
  parameter int DEBOUNCE_CYCLES = 16,
`endif
  parameter int CNT_W           = 32
) (
  input  wire logic            CLK_IN,
  input  wire logic            RST_N_IN,
  tone_period_meter_if.master  bus
);
  import tone_pkg::*;

  localparam int               TARGET_DELAY = MAIN_CLK_FREQ / TARGET_FREQ;
  localparam int               RUN_W        = $clog2(MATCH_COUNT + 1);
  localparam logic [CNT_W-1:0] C_TARGET     = CNT_W'(TARGET_DELAY);
  localparam logic [CNT_W-1:0] C_TOL        = CNT_W'(TOL_CYCLES);
  localparam logic [CNT_W-1:0] C_TIMEOUT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [RUN_W-1:0] C_RUN_MAX    = RUN_W'(MATCH_COUNT);

  meter_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_match, w_match_nxt;
  logic             r_lost, w_lost_nxt;

  logic             w_rise;
  logic [CNT_W-1:0] w_diff;
  logic             w_in_tol;
  logic [RUN_W-1:0] w_run_inc;

  tone_edge_sync #(
`ifdef TONE_DEBOUNCE_EN
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
  ) u_edge_sync (
    .CLK_IN   (CLK_IN),
    .RST_N_IN (RST_N_IN),
    .i_tone   (bus.TONE_IN),
    .o_rise   (w_rise)
  );

  // Larger minus smaller keeps the distance unsigned on both sides of target.
  assign w_diff    = (r_cnt >= C_TARGET) ? (r_cnt - C_TARGET) : (C_TARGET - r_cnt);
  assign w_in_tol  = (w_diff <= C_TOL);
  assign w_run_inc = (r_run == C_RUN_MAX) ? r_run : (r_run + RUN_W'(1));

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_run    <= '0;
      r_valid  <= 1'b0;
      r_match  <= 1'b0;
      r_lost   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_run    <= w_run_nxt;
      r_valid  <= w_valid_nxt;
      r_match  <= w_match_nxt;
      r_lost   <= w_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_run_nxt    = r_run;
    w_valid_nxt  = 1'b0;
    w_match_nxt  = r_match;
    w_lost_nxt   = r_lost;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = CNT_W'(1);
          w_lost_nxt  = 1'b0;
        end
      end

      MEASURE: begin
        // A rise on the timeout cycle still closes a valid period.
        if (w_rise) begin
          w_period_nxt = r_cnt;
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = CNT_W'(1);
          if (w_in_tol) begin
            w_run_nxt   = w_run_inc;
            w_match_nxt = (w_run_inc == C_RUN_MAX);
          end else begin
            w_run_nxt   = '0;
            w_match_nxt = 1'b0;
          end
        end else if (r_cnt >= C_TIMEOUT) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_lost_nxt  = 1'b1;
          w_match_nxt = 1'b0;
          w_run_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.PERIOD_o       = r_period;
  assign bus.PERIOD_VALID_o = r_valid;
  assign bus.TONE_MATCH_o   = r_match;
  assign bus.SIGNAL_LOST_o  = r_lost;
  assign bus.LED_D9         = r_match;

endmodule

`default_nettype wire

// File: tb/tb_tone_period_meter.sv
//------------------------------------------------------------------------------
// tb_tone_period_meter: randomized tone stimulus, scoreboard-checked strobes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tone_period_meter;

  localparam int CNT_W   = 32;
  localparam int MAIN_HZ = 12_000;
  localparam int TGT_HZ  = 440;
  localparam int TGT     = MAIN_HZ / TGT_HZ;   // 27 cycles
  localparam int TOL     = 3;
  localparam int MC      = 4;
  localparam int TMO     = 200;
  localparam int DEB     = 4;

  typedef struct {
    int period;
    bit match;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_period_meter_if #(.CNT_W(CNT_W)) bus ();

  tone_period_meter #(
    .MAIN_CLK_FREQ   (MAIN_HZ),
    .TARGET_FREQ     (TGT_HZ),
    .TOL_CYCLES      (TOL),
    .MATCH_COUNT     (MC),
    .TIMEOUT_CYCLES  (TMO),
`ifdef TONE_DEBOUNCE_EN
    .DEBOUNCE_CYCLES (DEB),
`endif
    .CNT_W           (CNT_W)
  ) dut (
    .CLK_IN   (clk),
    .RST_N_IN (rst_n),
    .bus      (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   prev_valid = 1'b0;

  // Reference model state: pin-level rise times, not DUT internals.
  bit   armed = 1'b0;
  bit   cur   = 1'b0;
  int   last_rise = 0;
  int   run = 0;
  int   last_period = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_rise();
    int d;
    int ad;
    exp_t e;
    if (!armed) begin
      armed     = 1'b1;
      last_rise = cyc;
      return;
    end
    d         = cyc - last_rise;
    last_rise = cyc;
    if (d > TMO) begin
      run = 0;          // signal was lost; this rise only re-arms
      return;
    end
    ad  = (d > TGT) ? d - TGT : TGT - d;
    run = (ad <= TOL) ? ((run < MC) ? run + 1 : MC) : 0;
    last_period = d;
    e.period = d;
    e.match  = (run == MC);
    sb.push_back(e);
  endfunction

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (v && !cur) model_rise();
      cur = v;
      bus.TONE_IN = v;
    end
  endtask

  task automatic tone_period(input int p, input int h);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  // Short high pulse; with the debounce filter it is invisible to the model.
  task automatic glitch(input int n);
`ifdef TONE_DEBOUNCE_EN
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.TONE_IN = 1'b1;
    end
`else
    drive(1'b1, n);
`endif
  endtask

  task automatic hold_low_until(input int since_rise);
    while (cyc - last_rise < since_rise) drive(1'b0, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.PERIOD_VALID_o) begin
      chk("strobe_width", prev_valid, 0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got period %0d expected no strobe", bus.PERIOD_o);
      end else begin
        mon_e = sb.pop_front();
        chk("period", bus.PERIOD_o, mon_e.period);
        chk("tone_match", bus.TONE_MATCH_o, mon_e.match);
        chk("led_d9", bus.LED_D9, mon_e.match);
      end
    end
    prev_valid = rst_n && bus.PERIOD_VALID_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int h;
    bus.TONE_IN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", bus.PERIOD_o, 0);
    chk("rst_valid", bus.PERIOD_VALID_o, 0);
    chk("rst_match", bus.TONE_MATCH_o, 0);
    chk("rst_lost", bus.SIGNAL_LOST_o, 1);
    chk("rst_led", bus.LED_D9, 0);
    rst_n = 1'b1;
    drive(1'b0, 5);
    chk("idle_lost", bus.SIGNAL_LOST_o, 1);

    // On-target tone: lock on the fourth strobe.
    for (int i = 0; i < 8; i++) tone_period(TGT, 13);
    chk("lock_match", bus.TONE_MATCH_o, run == MC);
    chk("lock_lost", bus.SIGNAL_LOST_o, 0);

    // Off-target tone.
    for (int i = 0; i < 6; i++) tone_period(TGT - TOL - 1, 11);
    chk("off_match", bus.TONE_MATCH_o, 0);

    // Tolerance edges on both sides.
    for (int i = 0; i < 4; i++) tone_period(TGT + TOL, 14);
    tone_period(TGT + TOL + 1, 14);
    for (int i = 0; i < 4; i++) tone_period(TGT - TOL, 10);
    tone_period(TGT - TOL - 1, 10);

    // Randomized periods, biased toward the tolerance window.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) p = $urandom_range(TGT + TOL, TGT - TOL);
      else                           p = $urandom_range(TGT + 7, TGT - 7);
      h = $urandom_range(p - 5, 5);
      tone_period(p, h);
    end

    // Glitch inside an otherwise locked tone.
    for (int i = 0; i < 5; i++) tone_period(TGT, 12);
    drive(1'b1, 12);
    drive(1'b0, 5);
    glitch(2);
    drive(1'b0, 8);
    for (int i = 0; i < 2; i++) tone_period(TGT, 12);

    // Loss of signal after lock.
    for (int i = 0; i < 5; i++) tone_period(TGT, 13);
    hold_low_until(TMO - 5);
    chk("pre_timeout_lost", bus.SIGNAL_LOST_o, 0);
    chk("pre_timeout_match", bus.TONE_MATCH_o, 1);
    hold_low_until(TMO + DEB + 10);
    chk("timeout_lost", bus.SIGNAL_LOST_o, 1);
    chk("timeout_match", bus.TONE_MATCH_o, 0);
    chk("timeout_led", bus.LED_D9, 0);
    chk("timeout_period", bus.PERIOD_o, last_period);

    // Re-acquire, then reset in the middle of a period.
    tone_period(TGT, 13);
    drive(1'b1, 10);
    drive(1'b0, 3);
    #2;
    rst_n = 1'b0;
    bus.TONE_IN = 1'b0;
    cur = 1'b0;
    armed = 1'b0;
    run = 0;
    #1;
    chk("mid_rst_period", bus.PERIOD_o, 0);
    chk("mid_rst_valid", bus.PERIOD_VALID_o, 0);
    chk("mid_rst_lost", bus.SIGNAL_LOST_o, 1);
    chk("mid_rst_led", bus.LED_D9, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5);
    for (int i = 0; i < 6; i++) tone_period(TGT, 12);
    chk("relock_match", bus.TONE_MATCH_o, 1);

    drive(1'b0, 20);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
